// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the millisecond stopwatch.
// Holds the FSM state encoding, field widths and default moduli.
package stopwatch_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;

    localparam int MS_MOD_DEF  = 1000;
    localparam int SEC_MOD_DEF = 60;
    localparam int MIN_MOD_DEF = 60;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } sw_state_e;

endpackage

// File: rtl/stopwatch_mod_counter.sv
// Modulo-MOD counter stage for the stopwatch cascade.
// Ports: clk, reset (async, active-low), en -> cnt (count), carry (en & cnt==MOD-1).
module stopwatch_mod_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign carry = en && (cnt_q == LAST);
    assign cnt   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = carry ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digital_stopwatch_core.sv
// Millisecond stopwatch: prescaler + IDLE/RUN/HOLD FSM + ms/sec/min cascade.
// Ports: clk, reset (async, active-low), start, stop -> milisec, sec, min.
// Option: STOPWATCH_SATURATE_EN holds at the last value instead of wrapping.
module digital_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_MS = 1,
    parameter int MS_MOD       = MS_MOD_DEF,
    parameter int SEC_MOD      = SEC_MOD_DEF,
    parameter int MIN_MOD      = MIN_MOD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic [MS_W-1:0]  milisec,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MS - 1);

    sw_state_e     state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          running;
    logic          at_max;
    logic          adv;
    logic          tick;
    logic          ms_c;
    logic          sec_c;
    logic          min_wrap_unused;

    assign running = (state_q == ST_RUN);

`ifdef STOPWATCH_SATURATE_EN
    // Final value reached: freeze everything but keep the run state.
    assign at_max = (milisec == MS_W'(MS_MOD - 1))
                 && (sec == SEC_W'(SEC_MOD - 1))
                 && (min == MIN_W'(MIN_MOD - 1));
`else
    assign at_max = 1'b0;
`endif

    assign adv  = running && !at_max;
    assign tick = adv && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (adv) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    // stop wins over start; a stop seen in IDLE keeps the zeroed state.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_HOLD;
        end else if (start) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
        end
    end

    stopwatch_mod_counter #(.MOD(MS_MOD), .W(MS_W)) u_ms (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .cnt   (milisec),
        .carry (ms_c)
    );

    stopwatch_mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk   (clk),
        .reset (reset),
        .en    (ms_c),
        .cnt   (sec),
        .carry (sec_c)
    );

    stopwatch_mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk   (clk),
        .reset (reset),
        .en    (sec_c),
        .cnt   (min),
        .carry (min_wrap_unused)
    );

endmodule

// File: tb/tb_digital_stopwatch_core.sv
// Bench for digital_stopwatch_core: a full-size instance and a small-moduli
// instance driven in parallel and compared against an elapsed-time model.
module tb_digital_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [9:0] ms_a, ms_b;
    logic [5:0] sec_a, sec_b;
    logic [5:0] min_a, min_b;

    int n_vec = 0;
    int n_bad = 0;

    int  t_per [2] = '{1, 3};
    int  m_mod [2] = '{1000, 10};
    int  s_mod [2] = '{60, 6};
    int  n_mod [2] = '{60, 4};
    bit  run_m [2];
    int  pre_m [2];
    int  tot_m [2];

    always #5 clk = ~clk;

    digital_stopwatch_core #(.TICKS_PER_MS(1)) u_a (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .milisec (ms_a),
        .sec     (sec_a),
        .min     (min_a)
    );

    digital_stopwatch_core #(
        .TICKS_PER_MS(3), .MS_MOD(10), .SEC_MOD(6), .MIN_MOD(4)
    ) u_b (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .milisec (ms_b),
        .sec     (sec_b),
        .min     (min_b)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got min:sec.ms=%0d:%0d.%0d exp=%0d:%0d.%0d",
                     tag, got[21:16], got[15:10], got[9:0],
                     exp[21:16], exp[15:10], exp[9:0]);
        end
    endtask

    function automatic logic [31:0] pack(int m, int s, int ms);
        logic [31:0] r;
        r        = '0;
        r[9:0]   = ms[9:0];
        r[15:10] = s[5:0];
        r[21:16] = m[5:0];
        return r;
    endfunction

    function automatic logic [31:0] model_val(int k);
        int t;
        t = tot_m[k];
        return pack(t / (m_mod[k] * s_mod[k]), (t / m_mod[k]) % s_mod[k],
                    t % m_mod[k]);
    endfunction

    function automatic logic [31:0] got_a();
        return {10'd0, min_a, sec_a, ms_a};
    endfunction

    function automatic logic [31:0] got_b();
        return {10'd0, min_b, sec_b, ms_b};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            run_m[k] = 1'b0;
            pre_m[k] = 0;
            tot_m[k] = 0;
        end
    endtask

    // One clock edge of elapsed-time bookkeeping.
    task automatic model_edge(bit st, bit sp);
        int last;
        for (int k = 0; k < 2; k++) begin
            last = m_mod[k] * s_mod[k] * n_mod[k] - 1;
            if (run_m[k]) begin
                pre_m[k]++;
                if (pre_m[k] == t_per[k]) begin
                    pre_m[k] = 0;
                    if (tot_m[k] == last) begin
`ifdef STOPWATCH_SATURATE_EN
                        tot_m[k] = last;
`else
                        tot_m[k] = 0;
`endif
                    end else begin
                        tot_m[k]++;
                    end
                end
            end
            if (sp) run_m[k] = 1'b0;
            else if (st) run_m[k] = 1'b1;
        end
    endtask

    task automatic cyc(bit st, bit sp);
        start = st;
        stop  = sp;
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge(st, sp);
        #1;
        check("inst_a", got_a(), model_val(0));
        check("inst_b", got_b(), model_val(1));
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        start = 1'b1;
        stop  = 1'b0;
        #2;
        check("rst_a", got_a(), pack(0, 0, 0));
        repeat (3) cyc(1, 0);
        reset = 1'b1;
        repeat (5) cyc(0, 0);
        check("idle_a", got_a(), pack(0, 0, 0));

        repeat (1001) cyc(1, 0);
        check("run1s", got_a(), pack(0, 1, 0));
        repeat (499) cyc(1, 0);
        repeat (7000) cyc(1, 1);
        check("hold", got_a(), pack(0, 1, 500));
        repeat (61001) cyc(1, 0);
        check("resume", got_a(), pack(1, 2, 500));

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        reset = 1'b0;
        repeat (2) cyc(0, 0);
        reset = 1'b1;
        repeat (5124) cyc(1, 0);
        check("t5123", got_a(), pack(0, 5, 123));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_a", got_a(), pack(0, 0, 0));
        check("async_b", got_b(), pack(0, 0, 0));
        #1;
        reset = 1'b1;
        repeat (4) cyc(0, 0);
        check("post_idle", got_a(), pack(0, 0, 0));
        repeat (20) cyc(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
